// File: rtl/tt_project_mux_pkg.sv
// Shared types for the project multiplexer.
//   state_e  : switch sequencer states (QUIESCE -> RESET -> ACTIVE)
//   slice_lo : LSB position of project idx inside a packed NUM_PROJ*width bus
package tt_project_mux_pkg;

  typedef enum logic [1:0] {
    ST_QUIESCE = 2'd0,
    ST_RESET   = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_e;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/tt_project_mux_if.sv
// Selection control / status bundle of tt_project_mux.
//   sel_load_i : pulse, request a switch to sel_req_i
//   sel_req_i  : requested project index
//   active_o   : current project, or the target while quiescing
//   busy_o     : high whenever the sequencer is not ACTIVE
//   err_o      : one-cycle pulse, request index out of range
//   state_o    : sequencer state, for observation
// Handshake: sel_load_i is a single-cycle strobe sampled on every rising edge;
// there is no ready, requests made while busy are queued one deep (last wins).
interface tt_project_mux_if
  import tt_project_mux_pkg::*;
#(
  parameter int SEL_W = 2
);
  logic             sel_load_i;
  logic [SEL_W-1:0] sel_req_i;
  logic [SEL_W-1:0] active_o;
  logic             busy_o;
  logic             err_o;
  state_e           state_o;

  modport master (
    output sel_load_i, sel_req_i,
    input  active_o, busy_o, err_o, state_o
  );

  modport slave (
    input  sel_load_i, sel_req_i,
    output active_o, busy_o, err_o, state_o
  );
endinterface

// File: rtl/tt_bus_sel.sv
// NUM_PROJ x IO_W index mux with a zero gate.
//   bus_i : packed project buses, project i at [i*IO_W +: IO_W]
//   sel_i : project index
//   en_i  : when low the output is forced to all zeros
//   bus_o : selected slice or zero
module tt_bus_sel
  import tt_project_mux_pkg::*;
#(
  parameter int NUM_PROJ = 4,
  parameter int IO_W     = 8,
  parameter int SEL_W    = 2
) (
  input  logic [NUM_PROJ*IO_W-1:0] bus_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic                     en_i,
  output logic [IO_W-1:0]          bus_o
);

  always_comb begin
    bus_o = '0;
    if (en_i) begin
      for (int i = 0; i < NUM_PROJ; i++) begin
        if (sel_i == SEL_W'(i)) begin
          bus_o = bus_i[slice_lo(i, IO_W) +: IO_W];
        end
      end
    end
  end

endmodule

// File: rtl/tt_project_mux.sv
// Time-multiplexes NUM_PROJ Tiny-Tapeout-style projects onto one pad set.
// A switch is sequenced: gate the pads (QUIESCE), hold every project in
// reset (RESET), then release only the selected one (ACTIVE).
//   clk, rst_n      : tile clock, async active-low reset
//   ctrl            : selection control / status (tt_project_mux_if.slave)
//   proj_*_i        : packed per-project uo_out / uio_out / uio_oe
//   proj_rst_n_o    : per-project active-low reset
//   proj_ena_o      : per-project enable, one-hot or zero
//   uo_out, uio_out, uio_oe : pads, selected slice in ACTIVE, else zero
module tt_project_mux
  import tt_project_mux_pkg::*;
#(
  parameter int NUM_PROJ     = 4,
  parameter int IO_W         = 8,
  parameter int DEFAULT_PROJ = 0,
  parameter int GUARD_CYC    = 2,
  parameter int RST_CYC      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tt_project_mux_if.slave          ctrl,
  input  logic [NUM_PROJ*IO_W-1:0] proj_uo_out_i,
  input  logic [NUM_PROJ*IO_W-1:0] proj_uio_out_i,
  input  logic [NUM_PROJ*IO_W-1:0] proj_uio_oe_i,
  output logic [NUM_PROJ-1:0]      proj_rst_n_o,
  output logic [NUM_PROJ-1:0]      proj_ena_o,
  output logic [IO_W-1:0]          uo_out,
  output logic [IO_W-1:0]          uio_out,
  output logic [IO_W-1:0]          uio_oe
);

  localparam int SEL_W   = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1;
  localparam int CNT_MAX = (GUARD_CYC > RST_CYC) ? GUARD_CYC : RST_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC - 1);
  localparam logic [SEL_W-1:0] DEF_IDX  = SEL_W'(DEFAULT_PROJ);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             err_q, err_d;
  logic             load_ok;
  logic             req_hit;
  logic [SEL_W-1:0] req_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      cnt_q    <= RST_LD;
      active_q <= DEF_IDX;
      target_q <= DEF_IDX;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      target_q <= target_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    target_d = target_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    req_hit  = 1'b0;
    req_idx  = active_q;
    load_ok  = ctrl.sel_load_i && (int'(ctrl.sel_req_i) < NUM_PROJ);
    // Out-of-range requests only raise err; they never touch state or pending.
    err_d    = ctrl.sel_load_i && !load_ok;

    case (state_q)
      ST_ACTIVE: begin
        // A fresh load this cycle overrides whatever was queued while busy.
        pend_v_d = 1'b0;
        if (load_ok) begin
          req_hit = 1'b1;
          req_idx = ctrl.sel_req_i;
        end else if (pend_v_q) begin
          req_hit = 1'b1;
          req_idx = pend_q;
        end
        if (req_hit && (req_idx != active_q)) begin
          target_d = req_idx;
          state_d  = ST_QUIESCE;
          cnt_d    = GUARD_LD;
        end
      end
      ST_QUIESCE: begin
        if (load_ok) begin
          pend_v_d = 1'b1;
          pend_d   = ctrl.sel_req_i;
        end
        if (cnt_q == '0) begin
          active_d = target_q;
          state_d  = ST_RESET;
          cnt_d    = RST_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESET: begin
        if (load_ok) begin
          pend_v_d = 1'b1;
          pend_d   = ctrl.sel_req_i;
        end
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = RST_LD;
      end
    endcase
  end

  // The outgoing project keeps running (out of reset) through QUIESCE with
  // its pads gated; it is only forced into reset once RESET is entered.
  // The rst_n term makes the project resets follow the tile reset without
  // waiting for a clock edge.
  always_comb begin
    proj_rst_n_o = '0;
    proj_ena_o   = '0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      if (active_q == SEL_W'(i)) begin
        proj_rst_n_o[i] = rst_n && (state_q != ST_RESET);
        proj_ena_o[i]   = (state_q == ST_ACTIVE);
      end
    end
  end

  assign ctrl.active_o = (state_q == ST_QUIESCE) ? target_q : active_q;
  assign ctrl.busy_o   = (state_q != ST_ACTIVE);
  assign ctrl.err_o    = err_q;
  assign ctrl.state_o  = state_q;

  tt_bus_sel #(.NUM_PROJ(NUM_PROJ), .IO_W(IO_W), .SEL_W(SEL_W)) u_sel_uo (
    .bus_i(proj_uo_out_i), .sel_i(active_q), .en_i(state_q == ST_ACTIVE), .bus_o(uo_out)
  );
  tt_bus_sel #(.NUM_PROJ(NUM_PROJ), .IO_W(IO_W), .SEL_W(SEL_W)) u_sel_uio (
    .bus_i(proj_uio_out_i), .sel_i(active_q), .en_i(state_q == ST_ACTIVE), .bus_o(uio_out)
  );
  tt_bus_sel #(.NUM_PROJ(NUM_PROJ), .IO_W(IO_W), .SEL_W(SEL_W)) u_sel_oe (
    .bus_i(proj_uio_oe_i), .sel_i(active_q), .en_i(state_q == ST_ACTIVE), .bus_o(uio_oe)
  );

endmodule

// File: tb/tb_tt_project_mux.sv
// Bench for tt_project_mux: a 4-project instance driven by a cycle-by-cycle
// vector table plus random bus and async-reset sequences, and a 5-project
// instance for out-of-range request handling.
module tb_tt_project_mux;
  import tt_project_mux_pkg::*;

  logic clk;
  logic rst_n;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 4-project instance ----------------
  tt_project_mux_if #(.SEL_W(2)) c4 ();
  logic [31:0] uo4_bus, uio4_bus, oe4_bus;
  logic [3:0]  rstn4, ena4;
  logic [7:0]  uo4, uio4, oe4;

  tt_project_mux #(.NUM_PROJ(4), .IO_W(8), .DEFAULT_PROJ(0), .GUARD_CYC(2), .RST_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ctrl(c4),
    .proj_uo_out_i(uo4_bus), .proj_uio_out_i(uio4_bus), .proj_uio_oe_i(oe4_bus),
    .proj_rst_n_o(rstn4), .proj_ena_o(ena4),
    .uo_out(uo4), .uio_out(uio4), .uio_oe(oe4)
  );

  // ---------------- 5-project instance ----------------
  tt_project_mux_if #(.SEL_W(3)) c5 ();
  logic [39:0] uo5_bus, uio5_bus, oe5_bus;
  logic [4:0]  rstn5, ena5;
  logic [7:0]  uo5, uio5, oe5;

  tt_project_mux #(.NUM_PROJ(5), .IO_W(8), .DEFAULT_PROJ(0), .GUARD_CYC(2), .RST_CYC(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .ctrl(c5),
    .proj_uo_out_i(uo5_bus), .proj_uio_out_i(uio5_bus), .proj_uio_oe_i(oe5_bus),
    .proj_rst_n_o(rstn5), .proj_ena_o(ena5),
    .uo_out(uo5), .uio_out(uio5), .uio_oe(oe5)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] sl(input logic [39:0] bus, input int idx);
    return bus[idx*8 +: 8];
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       load;
    logic [1:0] req;
    logic       busy;
    logic [1:0] act;
    logic [3:0] ena;
    logic [3:0] rstn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic l, input logic [1:0] r, input logic b,
                     input logic [1:0] a, input logic [3:0] e, input logic [3:0] rn);
    vec_t v;
    v.load = l; v.req = r; v.busy = b; v.act = a; v.ena = e; v.rstn = rn;
    tbl.push_back(v);
  endtask

  task automatic repeat_add(input int n, input logic b, input logic [1:0] a,
                            input logic [3:0] e, input logic [3:0] rn);
    for (int k = 0; k < n; k++) add(1'b0, 2'd0, b, a, e, rn);
  endtask

  task automatic chk_pads4(input string tag, input logic busy, input int act);
    chk({tag, "_uo"},  {24'h0, uo4},  busy ? 32'h0 : {24'h0, sl({8'h0, uo4_bus}, act)});
    chk({tag, "_uio"}, {24'h0, uio4}, busy ? 32'h0 : {24'h0, sl({8'h0, uio4_bus}, act)});
    chk({tag, "_oe"},  {24'h0, oe4},  busy ? 32'h0 : {24'h0, sl({8'h0, oe4_bus}, act)});
  endtask

  // One clock: drive at the falling edge, check 1 time unit after the rising edge.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    c4.sel_load_i = v.load;
    c4.sel_req_i  = v.req;
    @(posedge clk);
    #1;
    c4.sel_load_i = 1'b0;
    chk({tag, "_busy"}, {31'h0, c4.busy_o}, {31'h0, v.busy});
    chk({tag, "_act"},  {30'h0, c4.active_o}, {30'h0, v.act});
    chk({tag, "_ena"},  {28'h0, ena4}, {28'h0, v.ena});
    chk({tag, "_rstn"}, {28'h0, rstn4}, {28'h0, v.rstn});
    chk({tag, "_err"},  {31'h0, c4.err_o}, 32'h0);
    chk_pads4(tag, v.busy, int'(v.act));
  endtask

  task automatic step5(input string tag, input logic l, input logic [2:0] r,
                       input logic e_err, input logic e_busy, input logic [2:0] e_act);
    @(negedge clk);
    c5.sel_load_i = l;
    c5.sel_req_i  = r;
    @(posedge clk);
    #1;
    c5.sel_load_i = 1'b0;
    chk({tag, "_err"},  {31'h0, c5.err_o}, {31'h0, e_err});
    chk({tag, "_busy"}, {31'h0, c5.busy_o}, {31'h0, e_busy});
    chk({tag, "_act"},  {29'h0, c5.active_o}, {29'h0, e_act});
    chk({tag, "_uo"},   {24'h0, uo5}, e_busy ? 32'h0 : {24'h0, sl(uo5_bus, int'(e_act))});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    c4.sel_load_i = 1'b0; c4.sel_req_i = '0;
    c5.sel_load_i = 1'b0; c5.sel_req_i = '0;
    uo4_bus  = {8'h5A, 8'h3C, 8'hC3, 8'hA5};
    uio4_bus = {8'h44, 8'h33, 8'h22, 8'h11};
    oe4_bus  = {8'hF0, 8'h0F, 8'hFF, 8'h81};
    uo5_bus  = {8'h77, 8'h5A, 8'h3C, 8'hC3, 8'hA5};
    uio5_bus = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    oe5_bus  = {8'h0A, 8'hF0, 8'h0F, 8'hFF, 8'h81};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rstn", {28'h0, rstn4}, 32'h0);
    chk("rst_ena",  {28'h0, ena4}, 32'h0);
    chk("rst_busy", {31'h0, c4.busy_o}, 32'h1);
    chk("rst_err",  {31'h0, c4.err_o}, 32'h0);
    chk("rst_act",  {30'h0, c4.active_o}, 32'h0);
    chk_pads4("rst", 1'b1, 0);
    chk("rst5_busy", {31'h0, c5.busy_o}, 32'h1);

    // Power-up: busy for RST_CYC edges after release, then project 0 live.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 4) begin
        chk($sformatf("pwr%0d_busy", k), {31'h0, c4.busy_o}, 32'h1);
        chk($sformatf("pwr%0d_rstn", k), {28'h0, rstn4}, 32'h0);
        chk_pads4($sformatf("pwr%0d", k), 1'b1, 0);
      end else begin
        chk("pwr_busy", {31'h0, c4.busy_o}, 32'h0);
        chk("pwr_rstn", {28'h0, rstn4}, 32'h1);
        chk("pwr_ena",  {28'h0, ena4}, 32'h1);
        chk("pwr_uo",   {24'h0, uo4}, 32'hA5);
        chk("pwr5_busy", {31'h0, c5.busy_o}, 32'h0);
      end
    end

    // Table: same-index load, switch 0->2, queued loads (last wins),
    // pending re-evaluation, fresh load overriding pending.
    add(1'b1, 2'd0, 1'b0, 2'd0, 4'b0001, 4'b0001);
    add(1'b0, 2'd0, 1'b0, 2'd0, 4'b0001, 4'b0001);
    add(1'b1, 2'd2, 1'b1, 2'd2, 4'b0000, 4'b0001);
    repeat_add(1, 1'b1, 2'd2, 4'b0000, 4'b0001);
    repeat_add(4, 1'b1, 2'd2, 4'b0000, 4'b0000);
    repeat_add(1, 1'b0, 2'd2, 4'b0100, 4'b0100);
    add(1'b1, 2'd1, 1'b1, 2'd1, 4'b0000, 4'b0100);
    add(1'b1, 2'd0, 1'b1, 2'd1, 4'b0000, 4'b0100);
    add(1'b1, 2'd3, 1'b1, 2'd1, 4'b0000, 4'b0000);
    repeat_add(3, 1'b1, 2'd1, 4'b0000, 4'b0000);
    repeat_add(1, 1'b0, 2'd1, 4'b0010, 4'b0010);
    repeat_add(2, 1'b1, 2'd3, 4'b0000, 4'b0010);
    repeat_add(4, 1'b1, 2'd3, 4'b0000, 4'b0000);
    repeat_add(1, 1'b0, 2'd3, 4'b1000, 4'b1000);
    add(1'b1, 2'd0, 1'b1, 2'd0, 4'b0000, 4'b1000);
    add(1'b1, 2'd1, 1'b1, 2'd0, 4'b0000, 4'b1000);
    repeat_add(4, 1'b1, 2'd0, 4'b0000, 4'b0000);
    repeat_add(1, 1'b0, 2'd0, 4'b0001, 4'b0001);
    add(1'b1, 2'd2, 1'b1, 2'd2, 4'b0000, 4'b0001);
    repeat_add(1, 1'b1, 2'd2, 4'b0000, 4'b0001);
    repeat_add(4, 1'b1, 2'd2, 4'b0000, 4'b0000);
    repeat_add(3, 1'b0, 2'd2, 4'b0100, 4'b0100);
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Random project buses: selected slice while ACTIVE on 2.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      uo4_bus = $urandom; uio4_bus = $urandom; oe4_bus = $urandom;
      #1;
      chk_pads4($sformatf("rnd_a%0d", k), 1'b0, 2);
    end
    // Switch to 1: pads exact zero for the 6 busy cycles, then slice 1.
    @(negedge clk);
    c4.sel_load_i = 1'b1; c4.sel_req_i = 2'd1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      c4.sel_load_i = 1'b0;
      uo4_bus = $urandom; uio4_bus = $urandom; oe4_bus = $urandom;
      #1;
      chk_pads4($sformatf("rnd_s%0d", k), (k < 6), 1);
    end
    uo4_bus  = {8'h5A, 8'h3C, 8'hC3, 8'hA5};
    uio4_bus = {8'h44, 8'h33, 8'h22, 8'h11};
    oe4_bus  = {8'hF0, 8'h0F, 8'hFF, 8'h81};

    // 5-project instance: out-of-range requests pulse err only.
    step5("e5_a", 1'b1, 3'd5, 1'b1, 1'b0, 3'd0);
    step5("e5_b", 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    step5("e5_c", 1'b1, 3'd0, 1'b0, 1'b0, 3'd0);
    step5("e5_d", 1'b1, 3'd7, 1'b1, 1'b0, 3'd0);
    step5("e5_e", 1'b1, 3'd4, 1'b0, 1'b1, 3'd4);
    step5("e5_f", 1'b1, 3'd6, 1'b1, 1'b1, 3'd4);
    for (int k = 0; k < 4; k++) step5($sformatf("e5_g%0d", k), 1'b0, 3'd0, 1'b0, 1'b1, 3'd4);
    for (int k = 0; k < 3; k++) step5($sformatf("e5_h%0d", k), 1'b0, 3'd0, 1'b0, 1'b0, 3'd4);
    chk("e5_ena", {27'h0, ena5}, 32'h10);

    // Async reset while in RESET with a queued request (dut4 active on 1).
    @(negedge clk);
    c4.sel_load_i = 1'b1; c4.sel_req_i = 2'd3;
    @(negedge clk);
    c4.sel_load_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    c4.sel_load_i = 1'b1; c4.sel_req_i = 2'd2;
    @(posedge clk);
    #1;
    c4.sel_load_i = 1'b0;
    chk("ar_pre_act", {30'h0, c4.active_o}, 32'h3);
    chk("ar_pre_rstn", {28'h0, rstn4}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_act",  {30'h0, c4.active_o}, 32'h0);
    chk("ar_rstn", {28'h0, rstn4}, 32'h0);
    chk("ar_ena",  {28'h0, ena4}, 32'h0);
    chk("ar_busy", {31'h0, c4.busy_o}, 32'h1);
    chk_pads4("ar", 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("ar_rel_busy", {31'h0, c4.busy_o}, 32'h0);
    chk("ar_rel_act",  {30'h0, c4.active_o}, 32'h0);
    chk("ar_rel_ena",  {28'h0, ena4}, 32'h1);
    // Queued request must have been discarded by the reset.
    repeat (3) @(posedge clk);
    #1;
    chk("ar_pend_busy", {31'h0, c4.busy_o}, 32'h0);
    chk("ar_pend_act",  {30'h0, c4.active_o}, 32'h0);
    chk("ar_pend_uo",   {24'h0, uo4}, 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
